gpu_cmd_dispatch: RTL

- Front-end scheduler for the GPU draw pipeline. Accepts packed draw commands over a valid/ready interface and buffers them in a small FIFO.
- Decodes each command's opcode, pulses a start to the matching drawing unit, and drives the 4-bit select of the colour/output mux directly downstream.
- Holds the select until that unit reports done, plus one drain cycle, so the registered mux captures the final output.

---
 rtl/gpu_cmd_dispatch.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/gpu_cmd_dispatch.sv
// Draw-command front end: queues packed commands, starts the matching drawing unit
// and holds the downstream mux select until that unit finishes plus one drain cycle.
module gpu_cmd_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024,
  parameter int CMD_W   = 64
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [CMD_W-1:0] CMD_DATA,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [5:0]       DONE,
  output logic [5:0]       START,
  output logic [3:0]       SEL,
  output logic [15:0]      COLOR,
  output logic [43:0]      ARGS,
  output logic             BUSY,
  output logic             ERR,
  output logic [1:0]       ERR_CODE
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  // One-hot START/DONE bit for each drawing opcode; zero for NOP and illegal codes.
  function automatic logic [5:0] unit_of(input logic [3:0] op);
    case (op)
      4'd0:    unit_of = 6'b000001;
      4'd1:    unit_of = 6'b000010;
      4'd2:    unit_of = 6'b000100;
      4'd3:    unit_of = 6'b001000;
      4'd4:    unit_of = 6'b010000;
      4'd10:   unit_of = 6'b100000;
      default: unit_of = 6'b000000;
    endcase
  endfunction

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             full, empty, push, pop;
  logic [CMD_W-1:0] head;
  logic [3:0]       head_op;
  logic [5:0]       head_unit;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [5:0]  unit_q, unit_d;
  logic [15:0] color_q, color_d;
  logic [43:0] args_q, args_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;

  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign push      = CMD_VALID & ~full;
  assign pop       = (state_q == S_IDLE) & ~empty;
  assign head      = mem_q[rptr_q];
  assign head_op   = head[CMD_W-1 -: 4];
  assign head_unit = unit_of(head_op);

  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= CMD_DATA;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unit_d  = unit_q;
    color_d = color_q;
    args_d  = args_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          op_d    = head_op;
          unit_d  = head_unit;
          color_d = head[CMD_W-5 -: 16];
          args_d  = head[43:0];
          if (head_unit != '0) begin
            state_d = S_ISSUE;
          end else if (head_op != 4'd15) begin
            err_d  = 1'b1;
            code_d = 2'b01;
          end
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done in the final cycle still counts as success.
        if ((DONE & unit_q) != '0) begin
          state_d = S_DRAIN;
        end else if (tmo_q == TW'(TIMEOUT-1)) begin
          err_d   = 1'b1;
          code_d  = 2'b10;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      unit_q  <= '0;
      color_q <= '0;
      args_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      unit_q  <= unit_d;
      color_q <= color_d;
      args_q  <= args_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign CMD_READY = ~full;
  assign SEL       = (state_q == S_IDLE) ? 4'd15 : op_q;
  assign START     = (state_q == S_ISSUE) ? unit_q : 6'b0;
  assign COLOR     = color_q;
  assign ARGS      = args_q;
  assign BUSY      = (state_q != S_IDLE) | ~empty;
  assign ERR       = err_q;
  assign ERR_CODE  = code_q;

endmodule
